// File: rtl/mem_arbiter_pkg.sv
// Shared widths, encodings and FSM state codes for the memory arbiter.
// Also provides the load zero-extension helper.
package mem_arbiter_pkg;

  localparam int ADDR_TYPE = 32;
  localparam int DATA_TYPE = 32;
  localparam int LS_TYPE   = 3;

  localparam logic [LS_TYPE-1:0] LS_BYTE = 3'b100;
  localparam logic [LS_TYPE-1:0] LS_HALF = 3'b101;
  localparam logic [LS_TYPE-1:0] LS_WORD = 3'b111;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic TRUE      = 1'b1;
  localparam logic FALSE     = 1'b0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_LS = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  function automatic logic [DATA_TYPE-1:0] ld_extend(input logic [LS_TYPE-1:0] ls_type,
                                                     input logic [DATA_TYPE-1:0] data);
    case (ls_type)
      LS_BYTE: ld_extend = {24'd0, data[7:0]};
      LS_HALF: ld_extend = {16'd0, data[15:0]};
      default: ld_extend = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between IF, LSB, the arbiter and the memory controller.
// master = arbiter side, slave = environment (requesters + memory controller).
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                 if_to_arb_enable;
  logic [ADDR_TYPE-1:0] if_to_arb_pc;
  logic                 arb_to_if_done;
  logic [DATA_TYPE-1:0] arb_to_if_result;

  logic                 lsb_to_arb_enable;
  logic                 lsb_to_arb_wr;
  logic [ADDR_TYPE-1:0] lsb_to_arb_addr;
  logic [LS_TYPE-1:0]   lsb_to_arb_ls_type;
  logic [DATA_TYPE-1:0] lsb_to_arb_st_val;
  logic                 arb_to_lsb_ld_done;
  logic                 arb_to_lsb_st_done;
  logic [DATA_TYPE-1:0] arb_to_lsb_ld_val;

  logic                 arb_to_mc_enable;
  logic                 arb_to_mc_wr;
  logic [ADDR_TYPE-1:0] arb_to_mc_addr;
  logic [LS_TYPE-1:0]   arb_to_mc_ls_type;
  logic [DATA_TYPE-1:0] arb_to_mc_st_val;
  logic                 mc_to_arb_done;
  logic [DATA_TYPE-1:0] mc_to_arb_data;

  modport master (
    input  if_to_arb_enable, if_to_arb_pc,
    output arb_to_if_done, arb_to_if_result,
    input  lsb_to_arb_enable, lsb_to_arb_wr, lsb_to_arb_addr, lsb_to_arb_ls_type, lsb_to_arb_st_val,
    output arb_to_lsb_ld_done, arb_to_lsb_st_done, arb_to_lsb_ld_val,
    output arb_to_mc_enable, arb_to_mc_wr, arb_to_mc_addr, arb_to_mc_ls_type, arb_to_mc_st_val,
    input  mc_to_arb_done, mc_to_arb_data
  );

  modport slave (
    output if_to_arb_enable, if_to_arb_pc,
    input  arb_to_if_done, arb_to_if_result,
    output lsb_to_arb_enable, lsb_to_arb_wr, lsb_to_arb_addr, lsb_to_arb_ls_type, lsb_to_arb_st_val,
    input  arb_to_lsb_ld_done, arb_to_lsb_st_done, arb_to_lsb_ld_val,
    input  arb_to_mc_enable, arb_to_mc_wr, arb_to_mc_addr, arb_to_mc_ls_type, arb_to_mc_st_val,
    output mc_to_arb_done, mc_to_arb_data
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin IF/LSB arbiter that presents one stable request at a time to the
// byte-serial memory controller and returns registered done pulses.
//
//   state   | meaning
//   IDLE    | no request outstanding; pick a candidate
//   BUSY_IF | fetch outstanding at the memory controller
//   BUSY_LS | load or store outstanding at the memory controller
//   DRAIN   | flushed fetch/load still in flight; result is discarded
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_TOP = 2'b11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clr,
  input  logic          io_buffer_full,
  mem_arbiter_if.master bus
);

  logic [1:0]           r_state;
  logic                 r_last_ls;
  logic                 r_mc_enable;
  logic                 r_mc_wr;
  logic [ADDR_TYPE-1:0] r_mc_addr;
  logic [LS_TYPE-1:0]   r_mc_ls_type;
  logic [DATA_TYPE-1:0] r_mc_st_val;
  logic                 r_if_done;
  logic [DATA_TYPE-1:0] r_if_result;
  logic                 r_ld_done;
  logic                 r_st_done;
  logic [DATA_TYPE-1:0] r_ld_val;

  logic w_lsb_blocked;
  logic w_if_cand;
  logic w_lsb_cand;
  logic w_grant_ls;
  logic w_grant_if;

  // A store stalled on a full UART keeps its turn: r_last_ls only moves on a grant.
  always_comb begin
    w_lsb_blocked = bus.lsb_to_arb_wr && (bus.lsb_to_arb_addr[17:16] == IO_TOP) && io_buffer_full;
    w_if_cand     = bus.if_to_arb_enable && !clr;
    w_lsb_cand    = bus.lsb_to_arb_enable && !w_lsb_blocked && (!clr || bus.lsb_to_arb_wr);
    w_grant_ls    = w_lsb_cand && (!w_if_cand || !r_last_ls);
    w_grant_if    = w_if_cand && !w_grant_ls;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_ls    <= TRUE;
      r_mc_enable  <= FALSE;
      r_mc_wr      <= MEM_READ;
      r_mc_addr    <= '0;
      r_mc_ls_type <= '0;
      r_mc_st_val  <= '0;
      r_if_done    <= FALSE;
      r_if_result  <= '0;
      r_ld_done    <= FALSE;
      r_st_done    <= FALSE;
      r_ld_val     <= '0;
    end else begin
      r_if_done   <= FALSE;
      r_if_result <= '0;
      r_ld_done   <= FALSE;
      r_st_done   <= FALSE;
      r_ld_val    <= '0;
      if (rdy) begin
        case (r_state)
          ST_IDLE: begin
            if (w_grant_ls) begin
              r_mc_enable  <= TRUE;
              r_mc_wr      <= bus.lsb_to_arb_wr;
              r_mc_addr    <= bus.lsb_to_arb_addr;
              r_mc_ls_type <= bus.lsb_to_arb_ls_type;
              r_mc_st_val  <= bus.lsb_to_arb_st_val;
              r_last_ls    <= TRUE;
              r_state      <= ST_BUSY_LS;
            end else if (w_grant_if) begin
              r_mc_enable  <= TRUE;
              r_mc_wr      <= MEM_READ;
              r_mc_addr    <= bus.if_to_arb_pc;
              r_mc_ls_type <= LS_WORD;
              r_mc_st_val  <= '0;
              r_last_ls    <= FALSE;
              r_state      <= ST_BUSY_IF;
            end
          end
          ST_BUSY_IF: begin
            if (bus.mc_to_arb_done) begin
              r_mc_enable <= FALSE;
              r_state     <= ST_IDLE;
              if (!clr) begin
                r_if_done   <= TRUE;
                r_if_result <= bus.mc_to_arb_data;
              end
            end else if (clr) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_BUSY_LS: begin
            if (bus.mc_to_arb_done) begin
              r_mc_enable <= FALSE;
              r_state     <= ST_IDLE;
              if (r_mc_wr == MEM_WRITE) begin
                r_st_done <= TRUE;
              end else if (!clr) begin
                r_ld_done <= TRUE;
                r_ld_val  <= ld_extend(r_mc_ls_type, bus.mc_to_arb_data);
              end
            end else if (clr && (r_mc_wr == MEM_READ)) begin
              r_state <= ST_DRAIN;
            end
          end
          default: begin
            if (bus.mc_to_arb_done) begin
              r_mc_enable <= FALSE;
              r_state     <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.arb_to_if_done     = r_if_done;
  assign bus.arb_to_if_result   = r_if_result;
  assign bus.arb_to_lsb_ld_done = r_ld_done;
  assign bus.arb_to_lsb_st_done = r_st_done;
  assign bus.arb_to_lsb_ld_val  = r_ld_val;
  assign bus.arb_to_mc_enable   = r_mc_enable;
  assign bus.arb_to_mc_wr       = r_mc_wr;
  assign bus.arb_to_mc_addr     = r_mc_addr;
  assign bus.arb_to_mc_ls_type  = r_mc_ls_type;
  assign bus.arb_to_mc_st_val   = r_mc_st_val;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, zero-extend, flushes,
// UART-full hold, rdy freeze and mid-transaction reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst, rdy, clr, io_buffer_full;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.IO_TOP(2'b11)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clr            (clr),
    .io_buffer_full (io_buffer_full),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!bus.arb_to_mc_enable && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_grant"}, {31'd0, bus.arb_to_mc_enable}, 32'd1);
  endtask

  task automatic mc_done(input logic [31:0] d);
    bus.mc_to_arb_done = 1'b1;
    bus.mc_to_arb_data = d;
    step();
    bus.mc_to_arb_done = 1'b0;
    bus.mc_to_arb_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
    bus.if_to_arb_enable = 0; bus.if_to_arb_pc = '0;
    bus.lsb_to_arb_enable = 0; bus.lsb_to_arb_wr = 0; bus.lsb_to_arb_addr = '0;
    bus.lsb_to_arb_ls_type = '0; bus.lsb_to_arb_st_val = '0;
    bus.mc_to_arb_done = 0; bus.mc_to_arb_data = '0;
    step(); step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_enable", {31'd0, bus.arb_to_mc_enable}, 32'd0);
    chk("rst_if_done", {31'd0, bus.arb_to_if_done}, 32'd0);
    chk("rst_ld_done", {31'd0, bus.arb_to_lsb_ld_done}, 32'd0);
    chk("rst_st_done", {31'd0, bus.arb_to_lsb_st_done}, 32'd0);
    chk("rst_mc_addr", bus.arb_to_mc_addr, 32'd0);

    // single fetch, with one rdy-low cycle that must ignore mc done
    bus.if_to_arb_enable = 1; bus.if_to_arb_pc = 32'h0000_1000;
    step();
    chk("fetch_enable", {31'd0, bus.arb_to_mc_enable}, 32'd1);
    chk("fetch_addr", bus.arb_to_mc_addr, 32'h0000_1000);
    chk("fetch_ls_type", {29'd0, bus.arb_to_mc_ls_type}, 32'd7);
    chk("fetch_wr", {31'd0, bus.arb_to_mc_wr}, 32'd0);
    bus.if_to_arb_enable = 0;
    rdy = 1'b0;
    mc_done(32'hFFFF_FFFF);
    rdy = 1'b1;
    chk("rdy_low_no_done", {31'd0, bus.arb_to_if_done}, 32'd0);
    chk("rdy_low_hold_en", {31'd0, bus.arb_to_mc_enable}, 32'd1);
    step();
    mc_done(32'h00A0_0093);
    chk("fetch_done", {31'd0, bus.arb_to_if_done}, 32'd1);
    chk("fetch_result", bus.arb_to_if_result, 32'h00A0_0093);
    step();
    chk("fetch_done_once", {31'd0, bus.arb_to_if_done}, 32'd0);
    chk("fetch_result_zero", bus.arb_to_if_result, 32'd0);
    chk("fetch_en_low", {31'd0, bus.arb_to_mc_enable}, 32'd0);

    // contention from reset: IF, LSB, IF, LSB
    do_reset();
    bus.if_to_arb_enable = 1; bus.if_to_arb_pc = 32'h0000_1000;
    bus.lsb_to_arb_enable = 1; bus.lsb_to_arb_wr = 0;
    bus.lsb_to_arb_addr = 32'h0000_2000; bus.lsb_to_arb_ls_type = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant("rr");
      chk($sformatf("rr_addr%0d", i), bus.arb_to_mc_addr, (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      mc_done(32'h1122_3344);
      chk($sformatf("rr_done%0d", i),
          {30'd0, bus.arb_to_if_done, bus.arb_to_lsb_ld_done}, (i % 2 == 0) ? 32'd2 : 32'd1);
      chk($sformatf("rr_gap%0d", i), {31'd0, bus.arb_to_mc_enable}, 32'd0);
    end
    bus.if_to_arb_enable = 0;

    // byte / half load zero-extend (LSB-only, pointer irrelevant)
    bus.lsb_to_arb_addr = 32'h0000_0010; bus.lsb_to_arb_ls_type = 3'b100;
    wait_grant("lb");
    bus.lsb_to_arb_enable = 0;
    step();
    mc_done(32'hDEAD_BE80);
    chk("lb_done", {31'd0, bus.arb_to_lsb_ld_done}, 32'd1);
    chk("lb_val", bus.arb_to_lsb_ld_val, 32'h0000_0080);
    bus.lsb_to_arb_enable = 1; bus.lsb_to_arb_ls_type = 3'b101;
    wait_grant("lh");
    bus.lsb_to_arb_enable = 0;
    mc_done(32'hDEAD_BEEF);
    chk("lh_val", bus.arb_to_lsb_ld_val, 32'h0000_BEEF);

    // flush on fetch with a pending store; last grant was LSB so IF goes first
    bus.if_to_arb_enable = 1; bus.if_to_arb_pc = 32'h0000_3000;
    bus.lsb_to_arb_enable = 1; bus.lsb_to_arb_wr = 1; bus.lsb_to_arb_addr = 32'h0000_4000;
    bus.lsb_to_arb_ls_type = 3'b111; bus.lsb_to_arb_st_val = 32'h0000_0055;
    step();
    chk("flif_addr", bus.arb_to_mc_addr, 32'h0000_3000);
    bus.if_to_arb_enable = 0;
    clr = 1; step(); clr = 0;
    chk("flif_en_held", {31'd0, bus.arb_to_mc_enable}, 32'd1);
    step();
    chk("flif_addr_held", bus.arb_to_mc_addr, 32'h0000_3000);
    mc_done(32'h1234_5678);
    chk("flif_no_done", {31'd0, bus.arb_to_if_done}, 32'd0);
    wait_grant("flif_next");
    chk("flif_next_addr", bus.arb_to_mc_addr, 32'h0000_4000);
    chk("flif_next_wr", {31'd0, bus.arb_to_mc_wr}, 32'd1);
    bus.lsb_to_arb_enable = 0;
    mc_done(32'h0);
    chk("flif_st_done", {31'd0, bus.arb_to_lsb_st_done}, 32'd1);

    // flush on store: completes, fields stay stable
    bus.lsb_to_arb_enable = 1; bus.lsb_to_arb_addr = 32'h0000_1234; bus.lsb_to_arb_st_val = 32'hCAFE_F00D;
    wait_grant("flst");
    bus.lsb_to_arb_enable = 0; bus.lsb_to_arb_addr = 32'h0; bus.lsb_to_arb_st_val = 32'h0;
    clr = 1; step(); clr = 0;
    step();
    chk("flst_addr", bus.arb_to_mc_addr, 32'h0000_1234);
    chk("flst_val", bus.arb_to_mc_st_val, 32'hCAFE_F00D);
    chk("flst_en", {31'd0, bus.arb_to_mc_enable}, 32'd1);
    mc_done(32'h0);
    chk("flst_st_done", {31'd0, bus.arb_to_lsb_st_done}, 32'd1);

    // UART full: IF served twice while store blocked, then store jumps ahead
    io_buffer_full = 1;
    bus.lsb_to_arb_enable = 1; bus.lsb_to_arb_wr = 1; bus.lsb_to_arb_addr = 32'h0003_0000;
    bus.lsb_to_arb_st_val = 32'h0000_0041;
    bus.if_to_arb_enable = 1; bus.if_to_arb_pc = 32'h0000_5000;
    wait_grant("uart1");
    chk("uart1_addr", bus.arb_to_mc_addr, 32'h0000_5000);
    mc_done(32'h0);
    wait_grant("uart2");
    chk("uart2_addr", bus.arb_to_mc_addr, 32'h0000_5000);
    io_buffer_full = 0;
    mc_done(32'h0);
    wait_grant("uart3");
    chk("uart3_addr", bus.arb_to_mc_addr, 32'h0003_0000);
    chk("uart3_wr", {31'd0, bus.arb_to_mc_wr}, 32'd1);
    bus.lsb_to_arb_enable = 0;
    mc_done(32'h0);
    chk("uart3_st_done", {31'd0, bus.arb_to_lsb_st_done}, 32'd1);

    // reset mid-transaction drops everything
    bus.if_to_arb_pc = 32'h0000_6000;
    wait_grant("mrst");
    bus.if_to_arb_enable = 0;
    rst = 1;
    bus.mc_to_arb_done = 1; bus.mc_to_arb_data = 32'h0BAD_0BAD;
    step();
    rst = 0; bus.mc_to_arb_done = 0;
    chk("mrst_en", {31'd0, bus.arb_to_mc_enable}, 32'd0);
    chk("mrst_no_done", {31'd0, bus.arb_to_if_done}, 32'd0);
    chk("mrst_addr", bus.arb_to_mc_addr, 32'd0);
    step();
    chk("mrst_idle", {31'd0, bus.arb_to_mc_enable}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and request sequencer between the fetch unit (IF), the load/store buffer (LSB) and the byte-serial memory controller. It latches one request at a time, holds it stable to the memory controller until that transaction completes, and returns a registered single-cycle done pulse with data to the winning requester. It also owns flush (`clr`) handling and the UART-full hold policy, so the memory controller only ever sees one clean, stable request.

## Interface
- `IO_TOP`, default 2'b11: value of addr[17:16] that selects the I/O (UART) region.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; low freezes all state.
- `clr` in 1: pipeline flush, single-cycle.
- `io_buffer_full` in 1: UART buffer full.
- `if_to_arb_enable` in 1: fetch request, level.
- `if_to_arb_pc` in 32: fetch address; always a 4-byte read.
- `arb_to_if_done` out 1: fetch complete pulse.
- `arb_to_if_result` out 32: instruction word, valid with done.
- `lsb_to_arb_enable` in 1: LSB request, level.
- `lsb_to_arb_wr` in 1: 1 = store.
- `lsb_to_arb_addr` in 32: byte address.
- `lsb_to_arb_ls_type` in 3: 3'b100 = 1 byte, 3'b101 = 2 bytes, 3'b111 = 4 bytes.
- `lsb_to_arb_st_val` in 32: store data, little-endian.
- `arb_to_lsb_ld_done` out 1: load complete pulse.
- `arb_to_lsb_st_done` out 1: store complete pulse.
- `arb_to_lsb_ld_val` out 32: zero-extended load data.
- `arb_to_mc_enable` out 1: request valid to the memory controller.
- `arb_to_mc_wr`, `arb_to_mc_addr` (32), `arb_to_mc_ls_type` (3), `arb_to_mc_st_val` (32) out: latched request fields.
- `mc_to_arb_done` in 1: transaction complete pulse.
- `mc_to_arb_data` in 32: read data, valid with done.

## Operation
- States: IDLE, BUSY_IF, BUSY_LS, DRAIN.
- **IDLE, candidate eligibility:**
  - IF is a candidate when `if_to_arb_enable` is high.
  - LSB is a candidate when `lsb_to_arb_enable` is high and the request is not blocked.
  - Blocked means: store, addr[17:16] == IO_TOP, and `io_buffer_full` high. A blocked store waits; it does not lose its round-robin turn.
- **IDLE, grant:**
  - If both are candidates, grant the one not served last, using the 1-bit pointer `last_ls`.
  - With `clr` high in IDLE: no IF or load grant; a store may still be granted.
- **Grant:**
  - Latch all fields into the request registers and assert `arb_to_mc_enable`.
  - Move to BUSY_IF or BUSY_LS and update `last_ls`.
  - For IF, drive ls_type = 3'b111 and wr = 0.
- **BUSY_\*:**
  - Hold every `arb_to_mc_*` output constant until `mc_to_arb_done`.
  - On done: pulse the matching done output with data and return to IDLE.
  - Load data: bytes beyond the access size are forced to zero.
- **clr while BUSY_IF or BUSY_LS (load):** go to DRAIN and keep enable asserted.
- **DRAIN:** on `mc_to_arb_done`, discard the data, emit no done pulse, and return to IDLE.
- **clr while BUSY_LS (store):** ignored; the store completes and `arb_to_lsb_st_done` fires.
- **clr coinciding with done:** done is suppressed for IF and loads, and still pulsed for stores.
- **`rdy` low:** state, pointer and request registers hold; done outputs are forced low.

## Timing
- **Reset values:** all outputs 0; state IDLE; `last_ls` = 1, so IF wins the first tie.
- **Grant:** request sampled in IDLE at edge t → `arb_to_mc_enable` high after t (registered).
- **Completion:** `mc_to_arb_done` sampled at edge d → requester done high for exactly the cycle after d; data valid in that cycle only, 0 otherwise.
- **Back-to-back:** state is IDLE after d, so the next grant is at edge d+1 and the next enable is high after d+1. `arb_to_mc_enable` is therefore low for at least one cycle between transactions.
- **Reset mid-transaction:** drop everything; no done pulse.

## Structure
- Shared definitions header:
  - `ADDR_TYPE`, `DATA_TYPE`, `LS_TYPE` widths.
  - ls_type encodings.
  - `MEM_READ` / `MEM_WRITE`.
  - `TRUE` / `FALSE`.
  - state encodings.
- No sub-module; single flat `always @(posedge clk)` FSM plus a combinational eligibility/grant block.

## Test plan
- **Single fetch:** IF req pc = 0x1000; mc done 3 cycles after enable with 0x00A00093 → `arb_to_if_done` one cycle later, result 0x00A00093; `arb_to_mc_ls_type` = 3'b111.
- **Contention:** both requesting continuously from reset → grants alternate IF, LSB, IF, LSB; no requester is served twice in a row while the other waits.
- **Byte load zero-extend:** LSB load, ls_type 3'b100, mc data 0xDEADBE80 → `ld_val` = 0x00000080.
- **Flush on fetch:** `clr` during BUSY_IF → no `if_done`; enable held until mc done; the next grant is the pending LSB store.
- **Flush on store:** `clr` during a store to 0x00001234 → `st_done` still fires; the mc fields held stable throughout.
- **UART full:** store to 0x00030000 with `io_buffer_full` = 1 → IF requests are granted, the store is not. Drop `io_buffer_full` → the store is granted next, ahead of IF.
